mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
- REQ-001: The module SHALL have no parameters; the state width is fixed at 4 bits, with A as MSB and D as LSB.
- REQ-002: Port clk, input, 1 bit: single clock; all state changes except preset and clear occur on its rising edge.
- REQ-003: Port c, input, 1 bit: clear (reset), asynchronous, active-low; while 0, all state bits are forced to 0.
- REQ-004: Port p, input, 1 bit: preset, asynchronous, active-high; while 1 and c=1, all state bits are forced to 1.
- REQ-005: Ports A, B, C, D, input, 1 bit each: present Gray state, supplied externally by the user (normally wired from A2..D2).
- REQ-006: Ports A2, B2, C2, D2, output, 1 bit each: registered state, which is the Q of four SR flip-flops.

Function
- REQ-007: Next state SHALL be the 4-bit reflected-Gray successor of {A,B,C,D}: gray(bin({A,B,C,D}) + 1 mod 16).
- REQ-008: The count sequence SHALL be 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then wrap to 0000 (mod 16).
- REQ-009: Each bit SHALL be held in an SR flip-flop driven by excitation logic:
  - S = next AND NOT present
  - R = NOT next AND present
- REQ-010: The SR flip-flop SHALL behave as follows on the rising clk edge:
  - S=0, R=0: hold
  - S=1, R=0: set to 1
  - S=0, R=1: clear to 0
  - S=1, R=1: hold
  The excitation logic never produces S=1, R=1.
- REQ-011: Latency SHALL be one clock: {A2..D2} after edge k equals the successor of {A..D} sampled at edge k.
- REQ-012: Exactly one output bit SHALL change per clock edge while c=1 and p=0 and the inputs equal the fed-back outputs.
- REQ-013: The inputs A..D are not required to equal the outputs; any 4-bit input value SHALL produce its Gray successor at the next edge.
- REQ-014: An input value that is a valid Gray code of any binary count SHALL map per REQ-008; all 16 codes are valid, so no illegal states exist.

Reset
- REQ-015: Clear SHALL take effect immediately and independently of clk: c=0 drives A2..D2 to 0000.
- REQ-016: When both are asserted (c=0 and p=1), clear SHALL take priority.
- REQ-017: When c returns to 1 (with p=0), counting SHALL resume at the next rising clk edge from the value on A..D.
- REQ-018: Preset SHALL take effect immediately: p=1 with c=1 drives A2..D2 to 1111.
- REQ-019: Assertion of clear or preset mid-count SHALL override the clock-edge update in the same cycle.
- REQ-020: Outputs SHALL be 0000 after power-up, provided c is pulsed low.

Structure
- REQ-021: A shared package SHALL hold:
  - the state width constant (4)
  - the 16-entry Gray sequence, used for the successor function
  - named SR input-encoding constants (HOLD, SET, CLR)
- REQ-022: One sub-module, srff, SHALL implement a single SR flip-flop with ports clk, c (asynchronous active-low clear), p (asynchronous preset), s, r and q; it is instantiated four times.
- REQ-023: The top level SHALL contain only the combinational successor and excitation logic plus the four srff instances.

Verification
- REQ-024: With c=0 and p=0 held for 1 ns, then c=1, the bench SHALL see A2..D2 = 0000 immediately, with no clk edge required.
- REQ-025: With outputs fed back and c=1, p=0 for 16 rising edges from 0000, the bench SHALL see the full REQ-008 sequence in order, returning to 0000 on the 16th edge.
- REQ-026: Wrap-around: with A..D = 1000, one edge SHALL give A2..D2 = 0000.
- REQ-027: Open-loop check: with A..D = 0101 and A2..D2 = 0000 before the edge, one edge SHALL give 0100.
- REQ-028: Preset and clear priority SHALL be checked:
  - mid-count p=1 between edges gives 1111 at once
  - then c=0 while p=1 gives 0000 at once
  - release of both, then one edge from 1111, gives 1110
- REQ-029: A checker SHALL confirm, on every edge of a 100-edge fed-back run, that the Hamming distance between consecutive outputs is exactly 1.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared constants for the 4-bit Gray-code counter: state width,
// Gray sequence table with successor lookup, and SR input encodings.
package mod_counter_pkg;

    localparam int STATE_W = 4;
    localparam int SEQ_LEN = 16;

    // Count order, index = binary count, value = Gray code {A,B,C,D}.
    localparam logic [STATE_W-1:0] GRAY_SEQ [SEQ_LEN] = '{
        4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
        4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8
    };

    // {s,r} encodings for one SR flip-flop.
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_CLR  = 2'b01;

    // Gray successor via table lookup; the 4-bit index wraps 15 -> 0.
    function automatic logic [STATE_W-1:0] gray_succ(
        input logic [STATE_W-1:0] g
    );
        logic [STATE_W-1:0] n;
        logic [3:0]         idx;
        n = GRAY_SEQ[0];
        for (int i = 0; i < SEQ_LEN; i++) begin
            idx = 4'(i);
            if (GRAY_SEQ[idx] == g) begin
                n = GRAY_SEQ[idx + 4'd1];
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/mod_counter_srff.sv
// Single SR flip-flop with asynchronous active-low clear (c, dominant)
// and asynchronous active-high preset (p). Ports: clk, c, p, s, r, q.
module srff
    import mod_counter_pkg::*;
(
    input  logic clk,
    input  logic c,
    input  logic p,
    input  logic s,
    input  logic r,
    output logic q
);

    logic q_q;
    logic q_d;

    // S=R=1 is treated as hold; the excitation logic never drives it.
    always_comb begin
        q_d = q_q;
        case ({s, r})
            SR_SET:  q_d = 1'b1;
            SR_CLR:  q_d = 1'b0;
            SR_HOLD: q_d = q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge c or posedge p) begin
        if (!c) begin
            q_q <= 1'b0;
        end else if (p) begin
            q_q <= 1'b1;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mod_counter.sv
// 4-bit reflected-Gray counter built from four SR flip-flops.
// Ports: clk, c (async clear, low), p (async preset, high),
// A..D present state in (A = MSB), A2..D2 registered state out.
module mod_counter
    import mod_counter_pkg::*;
(
    input  logic clk,
    input  logic c,
    input  logic p,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic A2,
    output logic B2,
    output logic C2,
    output logic D2
);

    logic [STATE_W-1:0] pres_w;
    logic [STATE_W-1:0] next_w;
    logic [STATE_W-1:0] q_w;
    logic [STATE_W-1:0] s_w;
    logic [STATE_W-1:0] r_w;

    assign pres_w = {A, B, C, D};
    assign next_w = gray_succ(pres_w);

    // Excitation is taken against each flop's own Q, so the register
    // always lands on the successor of A..D, even when A..D are driven
    // open-loop and differ from A2..D2. When fed back, Q equals A..D.
    assign s_w = next_w & ~q_w;
    assign r_w = ~next_w & q_w;

    for (genvar i = 0; i < STATE_W; i++) begin : g_ff
        srff u_ff (
            .clk (clk),
            .c   (c),
            .p   (p),
            .s   (s_w[i]),
            .r   (r_w[i]),
            .q   (q_w[i])
        );
    end

    assign {A2, B2, C2, D2} = q_w;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed reset/preset steps plus
// random open-loop inputs, checked against an arithmetic Gray model.
module tb_mod_counter;

    logic       clk;
    logic       c;
    logic       p;
    logic       fb;
    logic [3:0] drv;
    logic       A, B, C, D;
    logic       A2, B2, C2, D2;
    logic [3:0] outs;

    int vectors;
    int miscompares;

    assign outs = {A2, B2, C2, D2};
    assign {A, B, C, D} = fb ? outs : drv;

    mod_counter dut (
        .clk (clk),
        .c   (c),
        .p   (p),
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D),
        .A2  (A2),
        .B2  (B2),
        .C2  (C2),
        .D2  (D2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] to_bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [3:0] to_gray(input logic [3:0] n);
        return n ^ (n >> 1);
    endfunction

    function automatic logic [3:0] model_succ(input logic [3:0] g);
        return to_gray(to_bin(g) + 4'd1);
    endfunction

    function automatic int hamming(input logic [3:0] a, input logic [3:0] b);
        return $countones(a ^ b);
    endfunction

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq_tab [16];
    logic [3:0] prev;
    logic [3:0] expv;
    logic [3:0] rnd;

    initial begin
        vectors     = 0;
        miscompares = 0;
        seq_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                    4'b0110, 4'b0111, 4'b0101, 4'b0100,
                    4'b1100, 4'b1101, 4'b1111, 4'b1110,
                    4'b1010, 4'b1011, 4'b1001, 4'b1000};

        // Clear without any clock edge.
        fb  = 1'b1;
        drv = 4'b0000;
        c   = 1'b0;
        p   = 1'b0;
        #1;
        check("clear_low", outs, 4'b0000);
        c = 1'b1;
        #1;
        check("clear_release", outs, 4'b0000);

        // Full fed-back cycle from 0000.
        prev = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            edge_wait();
            expv = model_succ(prev);
            check("seq_model", outs, expv);
            check("seq_table", outs, seq_tab[(k + 1) % 16]);
            prev = outs;
        end
        check("seq_wrap", outs, 4'b0000);

        // Wrap-around, open-loop.
        fb  = 1'b0;
        drv = 4'b1000;
        edge_wait();
        check("wrap_1000", outs, 4'b0000);

        // Open-loop input different from registered output.
        drv = 4'b0101;
        check("openloop_pre", outs, 4'b0000);
        edge_wait();
        check("openloop_0101", outs, 4'b0100);

        // Preset/clear priority, mid-count.
        fb = 1'b1;
        edge_wait();
        check("resume_fb", outs, 4'b1100);
        p = 1'b1;
        #1;
        check("preset_now", outs, 4'b1111);
        c = 1'b0;
        #1;
        check("clear_over_preset", outs, 4'b0000);
        p = 1'b0;
        #1;
        c = 1'b1;
        #1;
        check("both_released", outs, 4'b0000);
        p = 1'b1;
        #1;
        check("preset_again", outs, 4'b1111);
        p = 1'b0;
        #1;
        check("preset_held", outs, 4'b1111);
        edge_wait();
        check("from_1111", outs, 4'b1110);

        // Random open-loop inputs against the model.
        fb = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rnd = 4'($urandom_range(0, 15));
            drv = rnd;
            edge_wait();
            check("rand_openloop", outs, model_succ(rnd));
        end

        // Fed-back run from a random start: one bit changes per edge.
        drv = 4'($urandom_range(0, 15));
        edge_wait();
        prev = outs;
        fb   = 1'b1;
        for (int k = 0; k < 100; k++) begin
            edge_wait();
            check_int("hamming", hamming(prev, outs), 1);
            check("fb_model", outs, model_succ(prev));
            prev = outs;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
